dmem_uart_tx: RTL and testbench
===============================

# dmem_uart_tx

Memory-mapped UART transmitter that responds on the core's data-memory port (`data_mem_addr`/`data_mem_wdata`/`data_mem_we` → `data_mem_out`), alongside the data RAM. The core writes bytes into a small FIFO through store instructions. A serializer FSM then shifts the bytes out as 8N1 frames on `txd`. Simulation firmware uses it to print results instead of relying on register-file inspection.

## Interface
- `AWIDTH`, 14: data-memory address width (bytes).
- `XLEN`, 32: data bus width.
- `BASE_ADDR`, 'h3F00: byte base of the 16-byte register window; must be 16-byte aligned.
- `FIFO_DEPTH`, 8: TX FIFO entries; power of two, 2..16.
- `DEFAULT_DIV`, 16'd9: reset value of BAUDDIV.

- `clk` input 1: single clock; all state is updated on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `addr` input AWIDTH: byte address from the core; `addr[1:0]` is ignored.
- `qin` input XLEN: write data.
- `we` input 4: byte write enables; `we[n]` qualifies `qin[8n+7:8n]`.
- `qout` output XLEN: registered read data. Reset value 0.
- `txd` output 1: serial line, registered. Idles high. Reset value 1.

## Operation
- Hit: `addr[AWIDTH-1:4] == BASE_ADDR[AWIDTH-1:4]`. Register select is `addr[3:2]`. A miss has no side effect, and `qout` is 0 on the next cycle.
- Reads have no side effects. `qout` is loaded every cycle from the addressed register.
- Offset 0x0, TXDATA:
  - Write with `we[0]=1` pushes `qin[7:0]`.
  - If the FIFO is full and no pop occurs on the same edge, the byte is dropped and OVF is set.
  - Reads return 0.
- Offset 0x4, STATUS (read-only except OVF):
  - Bit 0 FULL, bit 1 EMPTY, bit 2 BUSY (FSM not in IDLE), bit 3 OVF (sticky), bits [12:8] LEVEL; all other bits 0.
  - Write with `we[0]=1` and `qin[3]=1` clears OVF.
  - If an overflow happens on the same edge as the clear, set wins.
- Offset 0x8, BAUDDIV, bits [15:0]:
  - `we[0]` writes the low byte and `we[1]` writes the high byte; `we[3:2]` is ignored.
  - Bit period = BAUDDIV+1 clocks. BAUDDIV=0 gives 1 clock per bit.
  - A new value takes effect at the next bit boundary; the current bit completes with the old divider.
- Offset 0xC, CTRL: bit 0 EN, reset 1, written with `we[0]`. Clearing EN lets the current frame finish, then the FSM holds in IDLE.
- FIFO: circular buffer with wrapping read/write pointers. A simultaneous push and pop when full is accepted and LEVEL is unchanged. A push to an empty FIFO is poppable on the next edge.
- FSM states:
  - IDLE: `txd`=1. If EN and not EMPTY, pop into the shift register and go to START.
  - START: `txd`=0 for one bit period, then go to DATA with bit index 0.
  - DATA: `txd`=shift[0], LSB first. Shift at each bit boundary. After 8 bits, go to STOP.
  - STOP: `txd`=1 for one bit period. At the end, if EN and not EMPTY, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Bit counter: loaded with BAUDDIV at state entry, decremented each clock. A bit boundary occurs at 0.

## Timing
- A write sampled at edge E0 is reflected in STATUS/LEVEL from E0, so `qout` shows it when read at the next address cycle.
- From IDLE, the pop occurs at E1 and `txd` goes low after E1. Write-to-start-bit latency is 2 edges.
- Frame length is exactly 10×(BAUDDIV+1) clocks. Back-to-back frames are contiguous.
- `qout` latency is 1 cycle after `addr`, the same as the data RAM.
- `rst` asserted mid-frame: on the next edge `txd`=1, FSM=IDLE, FIFO empty, OVF=0, BAUDDIV=DEFAULT_DIV, EN=1, `qout`=0. The partial frame is abandoned.
- `rst` has priority over any simultaneous write.

## Test plan
- Reset applied, then read STATUS → `qout`=32'h0000_0002. Then read BAUDDIV → `qout`=32'h0000_0009. Throughout, `txd`=1.
- BAUDDIV=3, then write 0xA5 to TXDATA → `txd` goes low 2 edges later. Each level holds 4 clocks: 0,1,0,1,0,0,1,0,1,1. BUSY=1 for exactly 40 clocks.
- EN=0, then 9 writes 0x30..0x38 → FULL=1 and LEVEL=8 after the 8th write; the 9th sets OVF, giving STATUS=32'h0000_0809. Write 0x8 to STATUS → OVF=0. Set EN=1 → bytes 0x30..0x37 are sent in order.
- BAUDDIV=0, then write 0x01 and 0x80 on consecutive cycles → the stop bit of frame 1 is immediately followed by the start bit of frame 2. Total `txd` activity is 20 clocks.
- Mid-frame `rst` pulse during the DATA state → `txd`=1 next cycle and STATUS=32'h0000_0002. No further frame bits are sent.
- Write 32'h0000_1234 to BAUDDIV with `we`=4'b0010 → BAUDDIV=16'h1209. Write TXDATA with `we`=4'b0010 → no push (LEVEL stays 0). Write to BASE_ADDR+16 → no register changes.

Source files
------------

// File: rtl/dmem_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the core's data-memory port.
// Stores to TXDATA fill a small FIFO that a serializer drains onto txd.
module dmem_uart_tx #(
  parameter int                AWIDTH      = 14,
  parameter int                XLEN        = 32,
  parameter logic [AWIDTH-1:0] BASE_ADDR   = 'h3F00,
  parameter int                FIFO_DEPTH  = 8,
  parameter logic [15:0]       DEFAULT_DIV = 16'd9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AWIDTH-1:0] addr,
  input  logic [XLEN-1:0]   qin,
  input  logic [3:0]        we,
  output logic [XLEN-1:0]   qout,
  output logic              txd
);

  localparam int            PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int            CW       = PW + 1;
  localparam logic [CW-1:0] FULL_LVL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // register window decode
  logic       w_hit;
  logic [1:0] w_sel;
  logic       w_wr_tx;
  logic       w_wr_st;
  logic       w_wr_div;
  logic       w_wr_ctl;
  logic       w_unused;

  assign w_hit    = (addr[AWIDTH-1:4] == BASE_ADDR[AWIDTH-1:4]);
  assign w_sel    = addr[3:2];
  assign w_wr_tx  = w_hit && (w_sel == 2'd0) && we[0];
  assign w_wr_st  = w_hit && (w_sel == 2'd1) && we[0];
  assign w_wr_div = w_hit && (w_sel == 2'd2);
  assign w_wr_ctl = w_hit && (w_sel == 2'd3) && we[0];
  assign w_unused = ^{addr[1:0], qin[XLEN-1:16], we[3:2]};

  // control registers
  logic [15:0] r_div;
  logic        r_en;
  logic        r_ovf;

  // transmit FIFO
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_ovf_set;
  logic [7:0]    w_head;

  // serializer
  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_cnt;
  logic [7:0]  r_shift;
  logic [2:0]  r_bit;
  logic        r_txd;
  logic        w_tick;
  logic        w_pop;
  logic [15:0] w_cnt_nxt;
  logic [7:0]  w_shift_nxt;
  logic [2:0]  w_bit_nxt;
  logic        w_txd_nxt;

  // read path
  logic [XLEN-1:0] w_rd;
  logic [XLEN-1:0] r_qout;

  assign w_full    = (r_count == FULL_LVL);
  assign w_empty   = (r_count == '0);
  // a full FIFO still accepts a push when the serializer pops on the same edge
  assign w_push    = w_wr_tx && (!w_full || w_pop);
  assign w_ovf_set = w_wr_tx && w_full && !w_pop;
  assign w_head    = r_mem[r_rptr];
  assign w_tick    = (r_cnt == 16'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div <= DEFAULT_DIV;
      r_en  <= 1'b1;
      r_ovf <= 1'b0;
    end else begin
      if (w_wr_div && we[0]) r_div[7:0]  <= qin[7:0];
      if (w_wr_div && we[1]) r_div[15:8] <= qin[15:8];
      if (w_wr_ctl) r_en <= qin[0];
      if (w_ovf_set) r_ovf <= 1'b1;
      else if (w_wr_st && qin[3]) r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= qin[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (r_en && !w_empty) w_state_nxt = S_START;
      S_START: if (w_tick) w_state_nxt = S_DATA;
      S_DATA:  if (w_tick && (r_bit == 3'd7)) w_state_nxt = S_STOP;
      S_STOP:  if (w_tick) w_state_nxt = (r_en && !w_empty) ? S_START : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs and datapath controls
  always_comb begin
    w_pop       = 1'b0;
    w_cnt_nxt   = r_cnt - 16'd1;
    w_shift_nxt = r_shift;
    w_bit_nxt   = r_bit;
    w_txd_nxt   = 1'b1;
    // the divider is only sampled at a bit boundary, so a new BAUDDIV waits for it
    if ((r_state == S_IDLE) || w_tick) w_cnt_nxt = r_div;
    if (((r_state == S_IDLE) || ((r_state == S_STOP) && w_tick)) && r_en && !w_empty)
      w_pop = 1'b1;
    if (w_pop) w_shift_nxt = w_head;
    else if ((r_state == S_DATA) && w_tick) w_shift_nxt = {1'b0, r_shift[7:1]};
    if (r_state != S_DATA) w_bit_nxt = 3'd0;
    else if (w_tick) w_bit_nxt = r_bit + 3'd1;
    // txd is registered from the next-state view so the line changes with the state
    case (w_state_nxt)
      S_START: w_txd_nxt = 1'b0;
      S_DATA:  w_txd_nxt = w_shift_nxt[0];
      default: w_txd_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    r_cnt   <= w_cnt_nxt;
    r_shift <= w_shift_nxt;
    if (rst) begin
      r_bit <= 3'd0;
      r_txd <= 1'b1;
    end else begin
      r_bit <= w_bit_nxt;
      r_txd <= w_txd_nxt;
    end
  end

  always_comb begin
    w_rd = '0;
    if (w_hit) begin
      case (w_sel)
        2'd1: begin
          w_rd[0]    = w_full;
          w_rd[1]    = w_empty;
          w_rd[2]    = (r_state != S_IDLE);
          w_rd[3]    = r_ovf;
          w_rd[12:8] = 5'(r_count);
        end
        2'd2:    w_rd[15:0] = r_div;
        2'd3:    w_rd[0]    = r_en;
        default: w_rd = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_qout <= '0;
    else     r_qout <= w_rd;
  end

  assign qout = r_qout;
  assign txd  = r_txd;

endmodule

// File: tb/tb_dmem_uart_tx.sv
// Bench for dmem_uart_tx: queue-based line model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_dmem_uart_tx;

  localparam logic [13:0] A_TX  = 14'h3F00;
  localparam logic [13:0] A_ST  = 14'h3F04;
  localparam logic [13:0] A_DIV = 14'h3F08;
  localparam logic [13:0] A_CTL = 14'h3F0C;
  localparam logic [13:0] A_OUT = 14'h3F10;

  logic        clk;
  logic        rst;
  logic [13:0] addr;
  logic [31:0] qin;
  logic [3:0]  we;
  logic [31:0] qout;
  logic        txd;

  int checks = 0;
  int errors = 0;

  dmem_uart_tx #(
    .AWIDTH(14), .XLEN(32), .BASE_ADDR(14'h3F00), .FIFO_DEPTH(8), .DEFAULT_DIV(16'd9)
  ) dut (
    .clk(clk), .rst(rst), .addr(addr), .qin(qin), .we(we), .qout(qout), .txd(txd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural model: FIFO as a queue, a frame as a list of line levels
  logic [7:0]  m_q[$];
  bit          m_bits[$];
  bit          m_ovf;
  logic [15:0] m_div;
  bit          m_en;
  bit          m_act;
  int          m_hold;
  logic [31:0] m_qout;
  logic        m_txd;
  bit          m_valid = 1'b0;

  initial begin
    logic [31:0] rd;
    logic [7:0]  b;
    bit          hit;
    bit          start;
    logic [1:0]  sel;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_q.delete();
        m_bits.delete();
        m_ovf   = 1'b0;
        m_div   = 16'd9;
        m_en    = 1'b1;
        m_act   = 1'b0;
        m_hold  = 0;
        m_qout  = 32'd0;
        m_txd   = 1'b1;
        m_valid = 1'b1;
      end else begin
        hit = (addr[13:4] == 10'h3F0);
        sel = addr[3:2];
        rd  = 32'd0;
        if (hit) begin
          if (sel == 2'd1)
            rd = 32'(m_q.size() == 8) | (32'(m_q.size() == 0) << 1) | (32'(m_act) << 2)
               | (32'(m_ovf) << 3) | (32'(m_q.size()) << 8);
          else if (sel == 2'd2) rd = 32'(m_div);
          else if (sel == 2'd3) rd = 32'(m_en);
        end
        m_qout = rd;
        start = 1'b0;
        if (!m_act) start = m_en && (m_q.size() > 0);
        else begin
          m_hold = m_hold - 1;
          if (m_hold == 0) begin
            void'(m_bits.pop_front());
            if (m_bits.size() > 0) m_hold = int'(m_div) + 1;
            else begin
              m_act = 1'b0;
              start = m_en && (m_q.size() > 0);
            end
          end
        end
        if (start) begin
          b = m_q.pop_front();
          m_bits.delete();
          m_bits.push_back(1'b0);
          for (int i = 0; i < 8; i++) m_bits.push_back(b[i]);
          m_bits.push_back(1'b1);
          m_hold = int'(m_div) + 1;
          m_act  = 1'b1;
        end
        m_txd = m_act ? m_bits[0] : 1'b1;
        if (hit && sel == 2'd0 && we[0]) begin
          if (m_q.size() < 8) m_q.push_back(qin[7:0]);
          else m_ovf = 1'b1;
        end else if (hit && sel == 2'd1 && we[0] && qin[3]) m_ovf = 1'b0;
        if (hit && sel == 2'd2 && we[0]) m_div[7:0]  = qin[7:0];
        if (hit && sel == 2'd2 && we[1]) m_div[15:8] = qin[15:8];
        if (hit && sel == 2'd3 && we[0]) m_en = qin[0];
      end
    end
  end

  // per-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      checks++;
      if (txd !== m_txd) begin
        errors++;
        $display("FAIL txd t=%0t got %b want %b", $time, txd, m_txd);
      end
      checks++;
      if (qout !== m_qout) begin
        errors++;
        $display("FAIL qout t=%0t got %h want %h", $time, qout, m_qout);
      end
    end
  end

  // independent line receiver for literal byte checks
  int rx_q[$];
  bit rx_on  = 1'b0;
  int rx_div = 9;

  initial begin
    logic [7:0] v;
    int d;
    forever begin
      @(negedge clk);
      if (rx_on && m_valid && txd === 1'b0) begin
        d = rx_div;
        for (int i = 0; i < 8; i++) begin
          repeat (d + 1) @(negedge clk);
          v[i] = txd;
        end
        repeat (d + 1) @(negedge clk);
        if (rx_on) rx_q.push_back((txd === 1'b1) ? int'(v) : -1);
        repeat (d) @(negedge clk);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic [13:0] a, input logic [31:0] d, input logic [3:0] w);
    addr = a;
    qin  = d;
    we   = w;
    @(negedge clk);
  endtask

  task automatic rst_cyc();
    rst  = 1'b1;
    addr = 14'd0;
    qin  = 32'd0;
    we   = 4'd0;
    @(negedge clk);
    rst  = 1'b0;
  endtask

  bit lv[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  int exp_rx[11] = '{8'hA5, 8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h01, 8'h80};
  bit seq[47];
  int busy;
  int nbad;
  int first_low;
  int lows;

  initial begin
    rst  = 1'b1;
    addr = 14'd0;
    qin  = 32'd0;
    we   = 4'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // reset state
    cyc(A_ST, 32'd0, 4'd0);
    chk("rst_status", qout, 32'h0000_0002);
    cyc(A_DIV, 32'd0, 4'd0);
    chk("rst_div", qout, 32'h0000_0009);
    chk("rst_txd", {31'd0, txd}, 32'd1);
    rx_on = 1'b1;

    // single frame 0xA5 at BAUDDIV=3
    cyc(A_DIV, 32'd3, 4'b0001);
    rx_div = 3;
    cyc(A_TX, 32'hA5, 4'b0001);
    seq[0] = txd;
    busy = 0;
    for (int i = 1; i < 47; i++) begin
      cyc(A_ST, 32'd0, 4'd0);
      seq[i] = txd;
      busy += int'(qout[2]);
    end
    nbad = 0;
    first_low = -1;
    for (int i = 0; i < 47; i++) begin
      if (seq[i] == 1'b0 && first_low < 0) first_low = i;
      if (i >= 1 && i <= 40) begin
        if (seq[i] != lv[(i - 1) / 4]) nbad++;
      end else if (seq[i] != 1'b1) nbad++;
    end
    chk("a5_latency", 32'(first_low), 32'd1);
    chk("a5_wave", 32'(nbad), 32'd0);
    chk("a5_busy", 32'(busy), 32'd40);

    // fill with EN=0, overflow, clear, drain
    cyc(A_CTL, 32'd0, 4'b0001);
    for (int i = 0; i < 8; i++) cyc(A_TX, 32'h30 + 32'(i), 4'b0001);
    cyc(A_ST, 32'd0, 4'd0);
    chk("full_status", qout, 32'h0000_0801);
    cyc(A_TX, 32'h38, 4'b0001);
    cyc(A_ST, 32'd0, 4'd0);
    chk("ovf_status", qout, 32'h0000_0809);
    cyc(A_ST, 32'h8, 4'b0001);
    cyc(A_ST, 32'd0, 4'd0);
    chk("ovf_clear", qout, 32'h0000_0801);
    cyc(A_CTL, 32'd1, 4'b0001);
    repeat (340) cyc(14'd0, 32'd0, 4'd0);
    cyc(A_ST, 32'd0, 4'd0);
    chk("drained", qout, 32'h0000_0002);

    // back-to-back frames at BAUDDIV=0
    rx_div = 0;
    cyc(A_DIV, 32'd0, 4'b0011);
    cyc(A_TX, 32'h01, 4'b0001);
    cyc(A_TX, 32'h80, 4'b0001);
    busy = 0;
    for (int i = 0; i < 25; i++) begin
      cyc(A_ST, 32'd0, 4'd0);
      busy += int'(qout[2]);
    end
    chk("b2b_busy", 32'(busy), 32'd20);
    chk("rx_count", 32'(rx_q.size()), 32'd11);
    for (int i = 0; i < rx_q.size() && i < 11; i++) chk("rx_byte", 32'(rx_q[i]), 32'(exp_rx[i]));
    rx_on = 1'b0;

    // reset pulse mid-frame
    cyc(A_DIV, 32'd3, 4'b0001);
    cyc(A_TX, 32'h55, 4'b0001);
    repeat (10) cyc(14'd0, 32'd0, 4'd0);
    rst_cyc();
    chk("midrst_txd", {31'd0, txd}, 32'd1);
    cyc(A_ST, 32'd0, 4'd0);
    chk("midrst_status", qout, 32'h0000_0002);
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      cyc(14'd0, 32'd0, 4'd0);
      if (txd !== 1'b1) lows++;
    end
    chk("midrst_quiet", 32'(lows), 32'd0);

    // byte enables and out-of-window writes
    cyc(A_DIV, 32'h0000_1234, 4'b0010);
    cyc(A_DIV, 32'd0, 4'd0);
    chk("div_hi_byte", qout, 32'h0000_1209);
    cyc(A_TX, 32'h77, 4'b0010);
    cyc(A_ST, 32'd0, 4'd0);
    chk("tx_we1_nopush", qout, 32'h0000_0002);
    cyc(A_OUT, 32'hFFFF_FFFF, 4'hF);
    chk("miss_qout", qout, 32'd0);
    cyc(A_DIV, 32'd0, 4'd0);
    chk("miss_div", qout, 32'h0000_1209);
    cyc(A_CTL, 32'd0, 4'd0);
    chk("miss_ctl", qout, 32'h0000_0001);
    cyc(A_ST, 32'd0, 4'd0);
    chk("miss_status", qout, 32'h0000_0002);

    // randomized traffic against the model
    cyc(A_DIV, 32'd1, 4'b0011);
    for (int n = 0; n < 4000; n++) begin
      int r;
      int s;
      logic [13:0] a;
      logic [31:0] d;
      r = $urandom_range(0, 199);
      if (r < 2) rst_cyc();
      else if (r < 80) cyc(14'($urandom_range(0, 16383)), 32'd0, 4'd0);
      else begin
        s = $urandom_range(0, 4);
        a = (s == 4) ? 14'($urandom_range(0, 16383)) : (A_TX + 14'(4 * s) + 14'($urandom_range(0, 3)));
        d = $urandom;
        if (s == 2) d = 32'($urandom_range(0, 3));
        if (s == 3 && $urandom_range(0, 3) != 0) d[0] = 1'b1;
        cyc(a, d, 4'($urandom_range(0, 15)));
      end
    end
    repeat (20) cyc(14'd0, 32'd0, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
